// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    PRESS_DEB = 2'd1,
    HELD      = 2'd2,
    REL_DEB   = 2'd3
  } state_t;
  localparam logic [3:0] ROW_IDLE = 4'b1111;
  localparam int KEY_ROW_W = 2;
  localparam int KEY_COL_W = 2;
  localparam int KEY_W = KEY_ROW_W + KEY_COL_W;
  function automatic logic [KEY_COL_W-1:0] first_low(input logic [3:0] c);
    return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider producing a 1-clk tick every 2^DIV_W clks
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   tick : high for one clk while the divider is all-ones
module scan_tick_gen #(
  parameter int DIV_W = 18
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [DIV_W-1:0] div;
  always_ff @(posedge clk or posedge rst)
    if (rst) div <= '0;
    else div <= div + 1'b1;
  assign tick = &div;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with debounce, one key code per press
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   row       : active-low row drive, one row low at a time
//   col       : active-low column sense, asynchronous to clk
//   key_code  : row_idx*4 + col_idx of the last accepted key
//   key_valid : one-clk pulse when key_code is (re)issued
//   key_down  : high while the accepted key is held
// Define KEYPAD_REPEAT_EN to enable auto-repeat (REP_DELAY / REP_RATE ticks).
module keypad_scan import keypad_pkg::*; #(
  parameter int DIV_W     = 18,
  parameter int DEB_TICKS = 4,
  parameter int REP_DELAY = 64,
  parameter int REP_RATE  = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       row,
  input  logic [3:0]       col,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_down
);
  localparam logic [3:0] DEB = 4'(DEB_TICKS);
  logic tick;
  logic [3:0] c1, col_s, cnt;
  state_t state;
  logic [KEY_ROW_W-1:0] row_idx, cand_row;
  logic [KEY_COL_W-1:0] cand_col;
  logic low, accept, rel, rep_fire;
  scan_tick_gen #(.DIV_W(DIV_W)) u_tick (.clk(clk), .rst(rst), .tick(tick));
  assign low = !col_s[cand_col];
  // Acceptance and release are the ticks on which the debounce count completes;
  // DEB_TICKS=1 completes on the detecting tick itself.
  assign accept = tick && ((state == SCAN && col_s != ROW_IDLE && DEB == 4'd1) ||
                           (state == PRESS_DEB && low && cnt + 4'd1 == DEB));
  assign rel = tick && ((state == HELD && !low && DEB == 4'd1) ||
                        (state == REL_DEB && !low && cnt + 4'd1 == DEB));
`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_cnt;
  logic holding;
  assign holding = state == HELD || state == REL_DEB;
  // Down-counter reloaded at acceptance and after each repeat; fires at 1.
  assign rep_fire = tick && holding && rep_cnt == 16'd1 && !rel;
  always_ff @(posedge clk or posedge rst)
    if (rst) rep_cnt <= '0;
    else if (accept) rep_cnt <= 16'(REP_DELAY);
    else if (rel) rep_cnt <= '0;
    else if (tick && holding && rep_cnt != 16'd0) rep_cnt <= rep_fire ? 16'(REP_RATE) : rep_cnt - 16'd1;
`else
  localparam int unused_rep = REP_DELAY + REP_RATE;
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      c1 <= ROW_IDLE;
      col_s <= ROW_IDLE;
      state <= SCAN;
      row_idx <= '0;
      row <= 4'b1110;
      cand_row <= '0;
      cand_col <= '0;
      cnt <= '0;
      key_code <= '0;
      key_valid <= 1'b0;
      key_down <= 1'b0;
    end else begin
      c1 <= col;
      col_s <= c1;
      key_valid <= accept | rep_fire;
      if (tick)
        case (state)
          SCAN:
            if (col_s == ROW_IDLE) begin
              row_idx <= row_idx + 1'b1;
              row <= {row[2:0], row[3]};
            end else begin
              cand_row <= row_idx;
              cand_col <= first_low(col_s);
              cnt <= 4'd1;
              state <= accept ? HELD : PRESS_DEB;
            end
          PRESS_DEB:
            if (!low) state <= SCAN;
            else begin
              cnt <= cnt + 4'd1;
              if (accept) state <= HELD;
            end
          HELD:
            if (!low) begin
              cnt <= 4'd1;
              state <= rel ? SCAN : REL_DEB;
            end
          REL_DEB:
            if (low) state <= HELD;
            else begin
              cnt <= cnt + 4'd1;
              if (rel) state <= SCAN;
            end
        endcase
      if (accept) begin
        key_code <= {row_idx, state == SCAN ? first_low(col_s) : cand_col};
        key_down <= 1'b1;
      end
      if (rel) begin
        key_down <= 1'b0;
        row_idx <= row_idx + 1'b1;
        row <= {row[2:0], row[3]};
      end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed self-checking bench for keypad_scan with a 4x4 switch-matrix model
module tb_keypad_scan;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] row, col, key_code;
  logic key_valid, key_down;
  logic [15:0] pressed = '0;
  int checks = 0, errors = 0, nvalid = 0, cyc = 0, n0 = 0;
  int stamps [64];
  logic [3:0] last_code = '0;
  keypad_scan #(.DIV_W(2), .DEB_TICKS(3), .REP_DELAY(8), .REP_RATE(4)) dut (
    .clk(clk), .rst(rst), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );
  always #5 clk = ~clk;
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row[r] && pressed[r*4+c]) col[c] = 1'b0;
  end
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (key_valid) begin
      if (nvalid < 64) stamps[nvalid] = cyc;
      last_code = key_code;
      nvalid++;
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wait_row(input logic [3:0] exp, input int max, input string tag);
    for (int i = 0; i < max && row !== exp; i++) clks(1);
    check(tag, row, exp);
  endtask
  task automatic wait_up(input int max, input string tag);
    for (int i = 0; i < max && key_down !== 1'b0; i++) clks(1);
    check(tag, key_down, 0);
  endtask
  initial begin
    logic [3:0] seq [4];
    seq = '{4'b1011, 4'b0111, 4'b1110, 4'b1101};
    clks(3);
    check("reset_row", row, 4'b1110);
    check("reset_valid", key_valid, 0);
    check("reset_down", key_down, 0);
    check("reset_code", key_code, 0);
    @(negedge clk) rst = 1'b0;
    wait_row(4'b1101, 8, "scan_first_step");
    for (int i = 0; i < 4; i++) begin
      clks(3);
      check("scan_hold", row, i == 0 ? 4'b1101 : seq[i-1]);
      clks(1);
      check("scan_step", row, seq[i]);
    end
    // clean press of (2,1)
    n0 = nvalid;
    pressed[9] = 1'b1;
    clks(40);
    check("clean_count", nvalid - n0, 1);
    check("clean_code", last_code, 4'h9);
    check("clean_down", key_down, 1);
    pressed[9] = 1'b0;
    clks(4);
    check("release_early", key_down, 1);
    wait_up(24, "release_down");
    check("release_row", row, 4'b0111);
    wait_row(4'b1110, 8, "release_rescan");
    // bouncing (0,3)
    n0 = nvalid;
    for (int i = 0; i < 5; i++) begin
      pressed[3] = ~pressed[3];
      clks(4);
    end
    check("bounce_quiet", nvalid - n0, 0);
    clks(56);
    check("bounce_count", nvalid - n0, 1);
    check("bounce_code", key_code, 4'h3);
    pressed[3] = 1'b0;
    wait_up(24, "bounce_release");
    // two columns on row 1, then a second key while held
    n0 = nvalid;
    pressed[4] = 1'b1;
    pressed[6] = 1'b1;
    clks(40);
    check("multi_count", nvalid - n0, 1);
    check("multi_code", key_code, 4'h4);
    pressed[15] = 1'b1;
    clks(40);
    check("rollover_count", nvalid - n0, 1);
    check("rollover_code", key_code, 4'h4);
    check("rollover_down", key_down, 1);
    pressed = '0;
    wait_up(24, "multi_release");
    // reset two ticks into press debounce of (0,0)
    wait_row(4'b0111, 20, "deb_row3");
    pressed[0] = 1'b1;
    wait_row(4'b1110, 8, "deb_row0");
    n0 = nvalid;
    clks(9);
    check("deb_pending", key_down, 0);
    rst = 1'b1;
    #1;
    check("midrst_row", row, 4'b1110);
    check("midrst_code", key_code, 0);
    check("midrst_valid", key_valid, 0);
    pressed[0] = 1'b0;
    clks(3);
    rst = 1'b0;
    check("midrst_count", nvalid - n0, 0);
    check("midrst_row0", row, 4'b1110);
    wait_row(4'b1101, 8, "midrst_rescan");
    // long hold of (3,2)
    n0 = nvalid;
    pressed[14] = 1'b1;
    clks(240);
    check("hold_code", last_code, 4'hE);
    check("hold_down", key_down, 1);
`ifdef KEYPAD_REPEAT_EN
    check("rep_enough", nvalid - n0 >= 10, 1);
    check("rep_first_gap", stamps[n0+1] - stamps[n0], 32);
    check("rep_gap2", stamps[n0+2] - stamps[n0+1], 16);
    check("rep_gap3", stamps[n0+3] - stamps[n0+2], 16);
`else
    check("hold_count", nvalid - n0, 1);
`endif
    rst = 1'b1;
    #1;
    check("holdrst_down", key_down, 0);
    check("holdrst_code", key_code, 0);
    pressed = '0;
    clks(2);
    rst = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side companion to the multiplexed 4-digit 7-segment scanner. It scans a 4x4 matrix keypad by driving one row at a time and reading the four column lines.
- Debounces each key, then reports one 4-bit key code per press, ready for the dig3..dig0 registers that feed the display.
- Uses the same scan-tick idea as the display: a free-running divider sets the scan rate.

Parameters:
- DIV_W, default 18: scan tick period is 2^DIV_W clk cycles (the divider counter wraps).
- DEB_TICKS, default 4: number of consecutive stable ticks needed for both press and release; range 1..15.
- REP_DELAY, default 64: ticks from press to the first auto-repeat (only with KEYPAD_REPEAT_EN).
- REP_RATE, default 16: ticks between later repeats (only with KEYPAD_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- row  output  4  row drive, active-low, one-hot-zero; row[i]=0 selects row i.
- col  input  4  column sense, active-low; external pull-ups; asynchronous to clk.
- key_code  output  4  code of the last accepted key, = row_idx*4 + col_idx.
- key_valid  output  1  one-clk pulse when key_code is updated.
- key_down  output  1  level, high while an accepted key is held.

Behaviour:
- Reset (async, rst=1) sets:
  - row=4'b1110, key_code=0, key_valid=0, key_down=0.
  - divider=0, debounce counter=0, state=SCAN, row_idx=0, col synchronizer flops=4'b1111.
- Synchronizer: col passes through 2 flip-flops; col_s is the synchronized value. All decisions use col_s sampled on tick cycles only.
- Tick: a 1-clk pulse when the divider equals all-ones. The divider always runs.
- States:
  - SCAN: on tick, if col_s==4'b1111, row_idx increments mod 4 (3 wraps to 0) and row updates on the same edge. Otherwise latch cand_row=row_idx and cand_col=lowest index i with col_s[i]=0, set cnt=1, go to PRESS_DEB. The row is then frozen.
  - PRESS_DEB: on tick, if the latched column is still low (col_s[cand_col]==0), cnt++. Otherwise return to SCAN; row_idx does not advance on this tick. When cnt reaches DEB_TICKS: key_code={cand_row,cand_col}, key_valid=1 for exactly one clk, key_down=1, go to HELD.
  - With DEB_TICKS=1, acceptance happens on the detection tick itself: SCAN goes straight to HELD and key_valid pulses on the next clk.
  - HELD: on tick, if col_s[cand_col]==1, set cnt=1 and go to REL_DEB; otherwise stay.
  - REL_DEB: on tick, if col_s[cand_col]==1, cnt++. Otherwise return to HELD; key_down stays 1. When cnt reaches DEB_TICKS: key_down=0, row_idx increments, go to SCAN.
- Latency: key_valid rises 1 clk after the tick on which the press count reaches DEB_TICKS.
- A second key pressed while in HELD/REL_DEB is ignored: no rollover, no code change.
- Several columns low at detection: the lowest column index wins.
- key_code holds its value until the next accepted press and is never cleared by release.
- Reset asserted mid-debounce or mid-hold aborts everything immediately with no key_valid; after deassertion scanning restarts at row 0.

Optional Feature:
- KEYPAD_REPEAT_EN defined: a repeat counter runs in HELD/REL_DEB.
  - When it reaches REP_DELAY ticks after acceptance, key_valid pulses again with the same key_code, then every REP_RATE ticks after that.
  - The counter clears on entry to SCAN.
- Undefined: exactly one key_valid per press; no repeat logic is synthesized and REP_* are ignored.

Decomposition:
- Package keypad_pkg:
  - state encoding SCAN=0, PRESS_DEB=1, HELD=2, REL_DEB=3 (2 bits);
  - ROW_IDLE=4'b1111;
  - the key-code layout constants.
- Sub-module scan_tick_gen (parameter DIV_W; ports clk, rst, tick), reusable by the display scanner.
- Synchronizer, FSM and optional repeat stay in keypad_scan.

Test Plan (bench uses DIV_W=2, DEB_TICKS=3; keypad model pulls col[c] low while row[r]==0 and key (r,c) is closed):
- Reset: assert rst for 3 clks mid-run -> row=1110, key_valid=0, key_down=0, key_code=0 at once; row steps 1110->1101->1011->0111->1110 every 4 clks.
- Clean press of key (2,1) held 40 clks -> exactly one key_valid with key_code=4'h9, key_down=1. Release -> key_down=0 after 3 stable ticks, then scanning resumes.
- Bounce: key (0,3) toggles every 4 clks for 5 toggles, then stable -> key_valid only after 3 stable ticks, key_code=4'h3, exactly one pulse.
- Simultaneous (1,0) and (1,2) -> key_code=4'h4. Pressing (3,3) during HELD -> no new key_valid, key_code stays 4'h4.
- Reset mid-PRESS_DEB after 2 of 3 ticks -> no key_valid; after release of reset, scanning starts at row 0.
- With KEYPAD_REPEAT_EN, REP_DELAY=8, REP_RATE=4, key (3,2) held 60 ticks -> key_valid with code 4'hE at acceptance, then at +8 ticks, then every 4 ticks. Without the macro: one pulse only.
